// File: rtl/decode_stage_if.sv
// decode_stage_if: fetch-side and execute-side handshake bundle for decode_stage.
// master = the surrounding pipeline (fetch/execute), slave = the decode stage.
interface decode_stage_if #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 32
);
  // Fetch side
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_instr;
  logic [XLEN-1:0]  in_pc;
  logic             flush;
  // Execute side
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_pc;
  logic [4:0]       out_rd;
  logic [4:0]       out_rs1;
  logic [4:0]       out_rs2;
  logic [XLEN-1:0]  out_imm;
  logic [4:0]       out_alu_op;
  logic             out_word;
  logic             out_is_load;
  logic             out_is_store;
  logic             out_is_branch;
  logic             out_is_jump;
  logic             out_use_imm;
  logic             out_is_halt;
  logic             out_illegal;
  // Status
  logic [CNT_W-1:0] dec_count;

  modport master (
    output in_valid, in_instr, in_pc, flush, out_ready,
    input  in_ready, out_valid, out_pc, out_rd, out_rs1, out_rs2, out_imm,
           out_alu_op, out_word, out_is_load, out_is_store, out_is_branch,
           out_is_jump, out_use_imm, out_is_halt, out_illegal, dec_count
  );

  modport slave (
    input  in_valid, in_instr, in_pc, flush, out_ready,
    output in_ready, out_valid, out_pc, out_rd, out_rs1, out_rs2, out_imm,
           out_alu_op, out_word, out_is_load, out_is_store, out_is_branch,
           out_is_jump, out_use_imm, out_is_halt, out_illegal, dec_count
  );
endinterface

// File: rtl/decode_stage.sv
// decode_stage: RV64I instruction decoder with a two-entry elastic output
// buffer (output register + skid register), registered in_ready and flush.
// Optional feature macro: DECODE_RVM_EN enables the M-extension encodings
// (MUL..REMU, alu_op 10-17); without it those encodings decode as illegal.
module decode_stage #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 32
) (
  input logic          clk,
  input logic          reset,
  decode_stage_if.slave bus
);

  typedef enum logic [6:0] {
    OPC_LOAD     = 7'b0000011,
    OPC_OP_IMM   = 7'b0010011,
    OPC_AUIPC    = 7'b0010111,
    OPC_OP_IMM32 = 7'b0011011,
    OPC_STORE    = 7'b0100011,
    OPC_OP       = 7'b0110011,
    OPC_LUI      = 7'b0110111,
    OPC_OP32     = 7'b0111011,
    OPC_BRANCH   = 7'b1100011,
    OPC_JALR     = 7'b1100111,
    OPC_JAL      = 7'b1101111
  } opcode_e;

  typedef enum logic [4:0] {
    ALU_ADD  = 5'd0,
    ALU_SUB  = 5'd1,
    ALU_SLL  = 5'd2,
    ALU_SLT  = 5'd3,
    ALU_SLTU = 5'd4,
    ALU_XOR  = 5'd5,
    ALU_SRL  = 5'd6,
    ALU_SRA  = 5'd7,
    ALU_OR   = 5'd8,
    ALU_AND  = 5'd9
  } alu_op_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [XLEN-1:0] imm;
    logic [4:0]      alu_op;
    logic            word;
    logic            is_load;
    logic            is_store;
    logic            is_branch;
    logic            is_jump;
    logic            use_imm;
    logic            is_halt;
    logic            illegal;
  } bundle_t;

  localparam logic [31:0] HALT_INSTR = 32'h0000_8067;

  // Registered state
  bundle_t          r_out;
  logic             r_out_valid;
  bundle_t          r_skid;
  logic             r_skid_valid;
  logic             r_in_ready;
  logic [CNT_W-1:0] r_count;

  // Decode wires
  bundle_t         w_dec;
  logic            w_legal;
  logic [6:0]      w_opcode;
  logic [2:0]      w_f3;
  logic [6:0]      w_f7;
  logic [4:0]      w_rd;
  logic [4:0]      w_rs1;
  logic [4:0]      w_rs2;
  logic [XLEN-1:0] w_imm_i;
  logic [XLEN-1:0] w_imm_s;
  logic [XLEN-1:0] w_imm_b;
  logic [XLEN-1:0] w_imm_u;
  logic [XLEN-1:0] w_imm_j;

  // Handshake wires
  logic w_accept;
  logic w_drain;
  logic w_out_free;
  logic w_to_out;
  logic w_to_skid;
  logic w_skid_valid_nxt;

  assign w_opcode = bus.in_instr[6:0];
  assign w_f3     = bus.in_instr[14:12];
  assign w_f7     = bus.in_instr[31:25];
  assign w_rd     = bus.in_instr[11:7];
  assign w_rs1    = bus.in_instr[19:15];
  assign w_rs2    = bus.in_instr[24:20];

  assign w_imm_i = {{(XLEN-12){bus.in_instr[31]}}, bus.in_instr[31:20]};
  assign w_imm_s = {{(XLEN-12){bus.in_instr[31]}}, bus.in_instr[31:25], bus.in_instr[11:7]};
  assign w_imm_b = {{(XLEN-13){bus.in_instr[31]}}, bus.in_instr[31], bus.in_instr[7],
                    bus.in_instr[30:25], bus.in_instr[11:8], 1'b0};
  assign w_imm_u = {{(XLEN-32){bus.in_instr[31]}}, bus.in_instr[31:12], 12'h000};
  assign w_imm_j = {{(XLEN-21){bus.in_instr[31]}}, bus.in_instr[31], bus.in_instr[19:12],
                    bus.in_instr[20], bus.in_instr[30:21], 1'b0};

  // Combinational decode of the incoming instruction word into a bundle.
  always_comb begin
    // NOTE: every variable assigned here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    w_dec   = '0;
    w_legal = 1'b1;
    case (w_opcode)
      OPC_LUI, OPC_AUIPC: begin
        w_dec.rd      = w_rd;
        w_dec.imm     = w_imm_u;
        w_dec.use_imm = 1'b1;
        w_dec.alu_op  = ALU_ADD;
      end
      OPC_JAL: begin
        w_dec.rd      = w_rd;
        w_dec.imm     = w_imm_j;
        w_dec.use_imm = 1'b1;
        w_dec.is_jump = 1'b1;
        w_dec.alu_op  = ALU_ADD;
      end
      OPC_JALR: begin
        w_dec.rd      = w_rd;
        w_dec.rs1     = w_rs1;
        w_dec.imm     = w_imm_i;
        w_dec.use_imm = 1'b1;
        w_dec.is_jump = 1'b1;
        w_dec.alu_op  = ALU_ADD;
        w_legal       = (w_f3 == 3'b000);
      end
      OPC_BRANCH: begin
        w_dec.rs1       = w_rs1;
        w_dec.rs2       = w_rs2;
        w_dec.imm       = w_imm_b;
        w_dec.is_branch = 1'b1;
        case (w_f3)
          3'b000, 3'b001: w_dec.alu_op = ALU_SUB;
          3'b100, 3'b101: w_dec.alu_op = ALU_SLT;
          3'b110, 3'b111: w_dec.alu_op = ALU_SLTU;
          default:        w_legal      = 1'b0;
        endcase
      end
      OPC_LOAD: begin
        w_dec.rd      = w_rd;
        w_dec.rs1     = w_rs1;
        w_dec.imm     = w_imm_i;
        w_dec.use_imm = 1'b1;
        w_dec.is_load = 1'b1;
        w_dec.alu_op  = ALU_ADD;
        w_legal       = (w_f3 != 3'b111);
      end
      OPC_STORE: begin
        w_dec.rs1      = w_rs1;
        w_dec.rs2      = w_rs2;
        w_dec.imm      = w_imm_s;
        w_dec.use_imm  = 1'b1;
        w_dec.is_store = 1'b1;
        w_dec.alu_op   = ALU_ADD;
        w_legal        = !w_f3[2];
      end
      OPC_OP_IMM: begin
        w_dec.rd      = w_rd;
        w_dec.rs1     = w_rs1;
        w_dec.imm     = w_imm_i;
        w_dec.use_imm = 1'b1;
        case (w_f3)
          3'b000: w_dec.alu_op = ALU_ADD;
          3'b001: begin
            w_dec.alu_op = ALU_SLL;
            w_legal      = (bus.in_instr[31:26] == 6'b000000);
          end
          3'b010: w_dec.alu_op = ALU_SLT;
          3'b011: w_dec.alu_op = ALU_SLTU;
          3'b100: w_dec.alu_op = ALU_XOR;
          3'b101: begin
            if (bus.in_instr[31:26] == 6'b000000)      w_dec.alu_op = ALU_SRL;
            else if (bus.in_instr[31:26] == 6'b010000) w_dec.alu_op = ALU_SRA;
            else                                       w_legal      = 1'b0;
          end
          3'b110: w_dec.alu_op = ALU_OR;
          default: w_dec.alu_op = ALU_AND;
        endcase
      end
      OPC_OP_IMM32: begin
        w_dec.rd      = w_rd;
        w_dec.rs1     = w_rs1;
        w_dec.imm     = w_imm_i;
        w_dec.use_imm = 1'b1;
        w_dec.word    = 1'b1;
        if (w_f3 == 3'b000)                           w_dec.alu_op = ALU_ADD;
        else if (w_f3 == 3'b001 && w_f7 == 7'b0000000) w_dec.alu_op = ALU_SLL;
        else if (w_f3 == 3'b101 && w_f7 == 7'b0000000) w_dec.alu_op = ALU_SRL;
        else if (w_f3 == 3'b101 && w_f7 == 7'b0100000) w_dec.alu_op = ALU_SRA;
        else                                           w_legal      = 1'b0;
      end
      OPC_OP: begin
        w_dec.rd  = w_rd;
        w_dec.rs1 = w_rs1;
        w_dec.rs2 = w_rs2;
        case (w_f7)
          7'b0000000: begin
            case (w_f3)
              3'b000:  w_dec.alu_op = ALU_ADD;
              3'b001:  w_dec.alu_op = ALU_SLL;
              3'b010:  w_dec.alu_op = ALU_SLT;
              3'b011:  w_dec.alu_op = ALU_SLTU;
              3'b100:  w_dec.alu_op = ALU_XOR;
              3'b101:  w_dec.alu_op = ALU_SRL;
              3'b110:  w_dec.alu_op = ALU_OR;
              default: w_dec.alu_op = ALU_AND;
            endcase
          end
          7'b0100000: begin
            if (w_f3 == 3'b000)      w_dec.alu_op = ALU_SUB;
            else if (w_f3 == 3'b101) w_dec.alu_op = ALU_SRA;
            else                     w_legal      = 1'b0;
          end
`ifdef DECODE_RVM_EN
          // MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU map to 10 + funct3.
          7'b0000001: w_dec.alu_op = 5'd10 + {2'b00, w_f3};
`endif
          default: w_legal = 1'b0;
        endcase
      end
      OPC_OP32: begin
        w_dec.rd   = w_rd;
        w_dec.rs1  = w_rs1;
        w_dec.rs2  = w_rs2;
        w_dec.word = 1'b1;
        if (w_f7 == 7'b0000000 && w_f3 == 3'b000)      w_dec.alu_op = ALU_ADD;
        else if (w_f7 == 7'b0000000 && w_f3 == 3'b001) w_dec.alu_op = ALU_SLL;
        else if (w_f7 == 7'b0000000 && w_f3 == 3'b101) w_dec.alu_op = ALU_SRL;
        else if (w_f7 == 7'b0100000 && w_f3 == 3'b000) w_dec.alu_op = ALU_SUB;
        else if (w_f7 == 7'b0100000 && w_f3 == 3'b101) w_dec.alu_op = ALU_SRA;
`ifdef DECODE_RVM_EN
        // MULW, DIVW, DIVUW, REMW, REMUW; funct3 001..011 have no W form.
        else if (w_f7 == 7'b0000001 && (w_f3 == 3'b000 || w_f3[2]))
          w_dec.alu_op = 5'd10 + {2'b00, w_f3};
`endif
        else w_legal = 1'b0;
      end
      default: w_legal = 1'b0;
    endcase

    if (!w_legal) begin
      w_dec         = '0;
      w_dec.illegal = 1'b1;
    end
    w_dec.pc      = bus.in_pc;
    w_dec.is_halt = (bus.in_instr == HALT_INSTR);
  end

  // Handshake: new data goes to the output register only when it is free and
  // the skid has nothing older waiting; otherwise it lands in the skid.
  assign w_accept   = bus.in_valid && r_in_ready && !bus.flush;
  assign w_drain    = r_out_valid && bus.out_ready;
  assign w_out_free = !r_out_valid || w_drain;
  assign w_to_out   = w_accept && w_out_free && !r_skid_valid;
  assign w_to_skid  = w_accept && !w_to_out;
  assign w_skid_valid_nxt = !bus.flush &&
                            (w_to_skid || (r_skid_valid && !w_out_free));

  // Elastic buffer, registered ready and accept counter; flush wins over all.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the data registers are reset too, because the visible output
      // fields must read 0 out of reset; the skid shares the same reset for
      // uniformity even though its contents are never observed while empty.
      r_out        <= '0;
      r_out_valid  <= 1'b0;
      r_skid       <= '0;
      r_skid_valid <= 1'b0;
      r_in_ready   <= 1'b1;
      r_count      <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      r_skid_valid <= w_skid_valid_nxt;
      r_in_ready   <= !w_skid_valid_nxt;
      if (w_accept) r_count <= r_count + CNT_W'(1);

      if (bus.flush) begin
        r_out_valid <= 1'b0;
      end else if (w_out_free) begin
        if (r_skid_valid) begin
          r_out       <= r_skid;
          r_out_valid <= 1'b1;
        end else if (w_to_out) begin
          r_out       <= w_dec;
          r_out_valid <= 1'b1;
        end else begin
          r_out_valid <= 1'b0;
        end
      end

      if (w_to_skid) r_skid <= w_dec;
    end
  end

  assign bus.in_ready      = r_in_ready;
  assign bus.out_valid     = r_out_valid;
  assign bus.out_pc        = r_out.pc;
  assign bus.out_rd        = r_out.rd;
  assign bus.out_rs1       = r_out.rs1;
  assign bus.out_rs2       = r_out.rs2;
  assign bus.out_imm       = r_out.imm;
  assign bus.out_alu_op    = r_out.alu_op;
  assign bus.out_word      = r_out.word;
  assign bus.out_is_load   = r_out.is_load;
  assign bus.out_is_store  = r_out.is_store;
  assign bus.out_is_branch = r_out.is_branch;
  assign bus.out_is_jump   = r_out.is_jump;
  assign bus.out_use_imm   = r_out.use_imm;
  assign bus.out_is_halt   = r_out.is_halt;
  assign bus.out_illegal   = r_out.illegal;
  assign bus.dec_count     = r_count;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: randomized self-checking bench for decode_stage with a
// queue-based behavioural model and an ISA-level reference decoder.
// A narrow dec_count is used so that the counter wrap is exercised.
module tb_decode_stage;

  localparam int XLEN  = 64;
  localparam int CNT_W = 4;

  typedef struct packed {
    logic [63:0] pc;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [63:0] imm;
    logic [4:0]  alu_op;
    logic        word;
    logic        is_load;
    logic        is_store;
    logic        is_branch;
    logic        is_jump;
    logic        use_imm;
    logic        is_halt;
    logic        illegal;
  } exp_t;

  // alu_op for the register/immediate ALU group indexed by funct3
  localparam int REG_ALU [8] = '{0, 2, 3, 4, 5, 6, 8, 9};

  logic clk;
  logic reset;
  bit   chk_en;
  int   n_checks;
  int   n_pass;
  exp_t m_q[$];
  int   m_count;

  decode_stage_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();

  decode_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Decode straight from the ISA tables: pick format, class and operation,
  // then fill whichever fields that format carries.
  function automatic exp_t ref_decode(input logic [31:0] w, input logic [63:0] pc);
    exp_t       e;
    byte        fmt;
    int         alu;
    bit         word;
    bit         rvm;
    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    e = '0; fmt = "X"; alu = 0; word = 0; rvm = 0;
    opc = w[6:0]; f3 = w[14:12]; f7 = w[31:25];
`ifdef DECODE_RVM_EN
    rvm = 1;
`endif
    case (opc)
      7'h37, 7'h17: fmt = "U";
      7'h6f: begin fmt = "J"; e.is_jump = 1; end
      7'h67: if (f3 == 0) begin fmt = "I"; e.is_jump = 1; end
      7'h63: if (f3 != 2 && f3 != 3) begin
        fmt = "B"; e.is_branch = 1;
        alu = (f3 < 2) ? 1 : (f3 < 6) ? 3 : 4;
      end
      7'h03: if (f3 != 7) begin fmt = "I"; e.is_load = 1; end
      7'h23: if (f3 < 4) begin fmt = "S"; e.is_store = 1; end
      7'h13: begin
        fmt = "I"; alu = REG_ALU[f3];
        if (f3 == 1 && w[31:26] != 0) fmt = "X";
        if (f3 == 5) begin
          if (w[31:26] == 6'h10) alu = 7;
          else if (w[31:26] != 0) fmt = "X";
        end
      end
      7'h1b: begin
        word = 1;
        if (f3 == 0)                      begin fmt = "I"; alu = 0; end
        else if (f3 == 1 && f7 == 0)      begin fmt = "I"; alu = 2; end
        else if (f3 == 5 && f7 == 0)      begin fmt = "I"; alu = 6; end
        else if (f3 == 5 && f7 == 7'h20)  begin fmt = "I"; alu = 7; end
      end
      7'h33: begin
        if (f7 == 0)                          begin fmt = "R"; alu = REG_ALU[f3]; end
        else if (f7 == 7'h20 && f3 == 0)      begin fmt = "R"; alu = 1; end
        else if (f7 == 7'h20 && f3 == 5)      begin fmt = "R"; alu = 7; end
        else if (f7 == 1 && rvm)              begin fmt = "R"; alu = 10 + f3; end
      end
      7'h3b: begin
        word = 1;
        if (f7 == 0 && f3 == 0)               begin fmt = "R"; alu = 0; end
        else if (f7 == 0 && f3 == 1)          begin fmt = "R"; alu = 2; end
        else if (f7 == 0 && f3 == 5)          begin fmt = "R"; alu = 6; end
        else if (f7 == 7'h20 && f3 == 0)      begin fmt = "R"; alu = 1; end
        else if (f7 == 7'h20 && f3 == 5)      begin fmt = "R"; alu = 7; end
        else if (f7 == 1 && rvm && (f3 == 0 || f3 >= 4)) begin fmt = "R"; alu = 10 + f3; end
      end
      default: ;
    endcase
    if (fmt == "X") begin
      e = '0; e.pc = pc; e.illegal = 1;
      return e;
    end
    e.pc      = pc;
    e.word    = word;
    e.alu_op  = 5'(alu);
    e.is_halt = (w == 32'h00008067);
    e.use_imm = (fmt != "R" && fmt != "B");
    if (fmt == "R" || fmt == "I" || fmt == "U" || fmt == "J") e.rd  = w[11:7];
    if (fmt == "R" || fmt == "I" || fmt == "S" || fmt == "B") e.rs1 = w[19:15];
    if (fmt == "R" || fmt == "S" || fmt == "B")               e.rs2 = w[24:20];
    case (fmt)
      "I": e.imm = 64'($signed(w[31:20]));
      "S": e.imm = 64'($signed({w[31:25], w[11:7]}));
      "B": e.imm = 64'($signed({w[31], w[7], w[30:25], w[11:8], 1'b0}));
      "U": e.imm = 64'($signed({w[31:12], 12'h000}));
      "J": e.imm = 64'($signed({w[31], w[19:12], w[20], w[30:21], 1'b0}));
      default: e.imm = '0;
    endcase
    return e;
  endfunction

  function automatic exp_t dut_bundle();
    exp_t d;
    d.pc = bus.out_pc; d.rd = bus.out_rd; d.rs1 = bus.out_rs1; d.rs2 = bus.out_rs2;
    d.imm = bus.out_imm; d.alu_op = bus.out_alu_op; d.word = bus.out_word;
    d.is_load = bus.out_is_load; d.is_store = bus.out_is_store;
    d.is_branch = bus.out_is_branch; d.is_jump = bus.out_is_jump;
    d.use_imm = bus.out_use_imm; d.is_halt = bus.out_is_halt; d.illegal = bus.out_illegal;
    return d;
  endfunction

  // Drive one cycle of inputs, then advance the model across the same edge.
  // The model buffer is a FIFO of at most two decoded bundles.
  task automatic step(input bit iv, input logic [31:0] ins, input logic [63:0] pc,
                      input bit ordy, input bit fl);
    bit rdy;
    bus.in_valid = iv; bus.in_instr = ins; bus.in_pc = pc;
    bus.out_ready = ordy; bus.flush = fl;
    @(posedge clk);
    rdy = (m_q.size() < 2);
    if (fl) m_q.delete();
    else begin
      if (m_q.size() > 0 && ordy) void'(m_q.pop_front());
      if (iv && rdy) begin
        m_q.push_back(ref_decode(ins, pc));
        m_count = m_count + 1;
      end
    end
    #1;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    int sel;
    w = $urandom;
    sel = $urandom_range(0, 14);
    case (sel)
      0: w[6:0] = 7'h37;  1: w[6:0] = 7'h17;  2: w[6:0] = 7'h6f;
      3: w[6:0] = 7'h67;  4: w[6:0] = 7'h63;  5: w[6:0] = 7'h03;
      6: w[6:0] = 7'h23;  7: w[6:0] = 7'h13;  8: w[6:0] = 7'h1b;
      9: w[6:0] = 7'h33; 10: w[6:0] = 7'h3b; 11: w[6:0] = 7'h33;
      12: w = 32'h00008067;
      default: ;
    endcase
    case ($urandom_range(0, 3))
      0: w[31:25] = 7'h00;
      1: w[31:25] = 7'h20;
      2: w[31:25] = 7'h01;
      default: ;
    endcase
    if (sel == 12) w = 32'h00008067;
    return w;
  endfunction

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en && !reset) begin
      check("in_ready",  160'(bus.in_ready),  160'(m_q.size() < 2));
      check("out_valid", 160'(bus.out_valid), 160'(m_q.size() > 0));
      check("dec_count", 160'(bus.dec_count), 160'(m_count % (1 << CNT_W)));
      if (m_q.size() > 0) check("bundle", 160'(dut_bundle()), 160'(m_q[0]));
    end
  end

  initial begin
    exp_t e;
    int   c0;
    reset = 1'b1; chk_en = 0; n_checks = 0; n_pass = 0; m_count = 0;
    bus.in_valid = 0; bus.in_instr = '0; bus.in_pc = '0; bus.out_ready = 0; bus.flush = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    check("rst_out_valid", 160'(bus.out_valid), 160'(0));
    check("rst_in_ready",  160'(bus.in_ready),  160'(1));
    check("rst_dec_count", 160'(bus.dec_count), 160'(0));
    check("rst_fields",    160'(dut_bundle()),  160'(0));

    // Pin the reference decoder on hand-decoded words
    e = ref_decode(32'h00500093, 64'h1000);
    check("model_addi", {e.rd, e.rs1, e.imm, e.alu_op, e.use_imm, e.illegal},
          {5'd1, 5'd0, 64'd5, 5'd0, 1'b1, 1'b0});
    e = ref_decode(32'hFE000EE3, 64'h0);
    check("model_beq", {e.is_branch, e.alu_op, e.imm, e.rd},
          {1'b1, 5'd1, 64'hFFFF_FFFF_FFFF_FFFC, 5'd0});
    e = ref_decode(32'h00008067, 64'h0);
    check("model_ret", {e.is_jump, e.is_halt, e.rd, e.rs1, e.imm},
          {1'b1, 1'b1, 5'd0, 5'd1, 64'd0});
    e = ref_decode(32'h022081B3, 64'h0);
`ifdef DECODE_RVM_EN
    check("model_mul", {e.alu_op, e.rd, e.illegal}, {5'd10, 5'd3, 1'b0});
`else
    check("model_mul", {e.alu_op, e.rd, e.illegal}, {5'd0, 5'd0, 1'b1});
`endif

    chk_en = 1;

    // Directed: single instructions with the output always drained
    step(1, 32'h00500093, 64'h1000, 1, 0);
    check("addi_valid", 160'(bus.out_valid), 160'(1));
    check("addi_fields", {bus.out_rd, bus.out_rs1, bus.out_imm, bus.out_alu_op, bus.out_use_imm, bus.out_pc},
          {5'd1, 5'd0, 64'd5, 5'd0, 1'b1, 64'h1000});
    check("addi_count", 160'(bus.dec_count), 160'(1));
    step(1, 32'hFE000EE3, 64'h1004, 1, 0);
    check("beq_fields", {bus.out_is_branch, bus.out_alu_op, bus.out_imm},
          {1'b1, 5'd1, 64'hFFFF_FFFF_FFFF_FFFC});
    step(1, 32'h00008067, 64'h1008, 1, 0);
    check("ret_fields", {bus.out_is_jump, bus.out_is_halt, bus.out_rd, bus.out_rs1, bus.out_imm},
          {1'b1, 1'b1, 5'd0, 5'd1, 64'd0});
    step(1, 32'h022081B3, 64'h100C, 1, 0);
`ifdef DECODE_RVM_EN
    check("mul_fields", {bus.out_alu_op, bus.out_rd, bus.out_illegal}, {5'd10, 5'd3, 1'b0});
`else
    check("mul_fields", {bus.out_illegal, bus.out_alu_op, bus.out_is_jump}, {1'b1, 5'd0, 1'b0});
`endif
    step(0, 32'h0, 64'h0, 1, 0);

    // Backpressure: three back-to-back instructions with execute stalled
    c0 = m_count;
    step(1, 32'h00100093, 64'h2000, 0, 0);
    step(1, 32'h00200113, 64'h2004, 0, 0);
    check("bp_in_ready_low", 160'(bus.in_ready), 160'(0));
    check("bp_head_pc",      160'(bus.out_pc),   160'(64'h2000));
    step(1, 32'h00300193, 64'h2008, 0, 0);
    check("bp_third_blocked", 160'(bus.dec_count), 160'((c0 + 2) % (1 << CNT_W)));
    check("bp_head_held",     160'(bus.out_pc),    160'(64'h2000));
    step(1, 32'h00300193, 64'h2008, 1, 0);
    check("bp_second_pc",  160'(bus.out_pc),   160'(64'h2004));
    check("bp_ready_back", 160'(bus.in_ready), 160'(1));
    step(1, 32'h00300193, 64'h2008, 1, 0);
    check("bp_third_pc", 160'(bus.out_pc), 160'(64'h2008));
    step(0, 32'h0, 64'h0, 1, 0);

    // Flush with both registers full and an instruction offered
    step(1, 32'h00100093, 64'h3000, 0, 0);
    step(1, 32'h00200113, 64'h3004, 0, 0);
    c0 = m_count;
    step(1, 32'h00300193, 64'h3008, 0, 1);
    check("flush_out_valid", 160'(bus.out_valid), 160'(0));
    check("flush_in_ready",  160'(bus.in_ready),  160'(1));
    check("flush_count",     160'(bus.dec_count), 160'(c0 % (1 << CNT_W)));

    // Randomized traffic with one asynchronous reset mid-stream
    for (int i = 0; i < 800; i++) begin
      if (i == 400) begin
        #3 reset = 1'b1;
        #1;
        check("async_out_valid", 160'(bus.out_valid), 160'(0));
        check("async_in_ready",  160'(bus.in_ready),  160'(1));
        check("async_count",     160'(bus.dec_count), 160'(0));
        check("async_fields",    160'(dut_bundle()),  160'(0));
        m_q.delete();
        m_count = 0;
        bus.in_valid = 0; bus.flush = 0;
        @(posedge clk);
        #1 reset = 1'b0;
      end
      step($urandom_range(0, 9) < 7, rand_instr(), {$urandom, $urandom},
           $urandom_range(0, 9) < 6, $urandom_range(0, 24) == 0);
    end
    repeat (3) step(0, 32'h0, 64'h0, 1, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
